// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
// Packs a stream of 2-bit pixels into 32-bit words (16 pixels per word) and
// writes each completed word to VRAM port A. The pixel word has absolute
// priority over the Avalon-MM host. While a pixel word is pending, a host
// request is stalled for exactly that one cycle.
//
// Ports
//   CLK, RESET            : single clock, synchronous active-high reset
//   pix_frame_start       : 1-cycle pulse, starts (or restarts) a frame
//   pix_valid/pix_data    : offered pixel, 00 white .. 11 black
//   pix_ready             : pixel accepted this cycle when pix_valid is also high
//   frame_done            : 1-cycle pulse, the cycle after the last word is written
//   AVL_*                 : Avalon-MM host request; AVL_WAITREQUEST stalls it
//   vram_*                : VRAM port A (address, data, byte enables, write, read)
module fb_write_scheduler #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 144
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pix_frame_start,
  input  logic        pix_valid,
  input  logic [1:0]  pix_data,
  output logic        pix_ready,
  output logic        frame_done,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic        AVL_CS,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [11:0] AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic        AVL_WAITREQUEST,
  output logic [10:0] vram_addr,
  output logic [31:0] vram_data,
  output logic [3:0]  vram_byteena,
  output logic        vram_wren,
  output logic        vram_rden
);

  localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]  pack_cnt_q, pack_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [10:0] waddr_q, waddr_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_last_q, pend_last_d;
  logic [10:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        done_q, done_d;

  logic rdy, accept, last_x, last_y;

  assign last_x = (x_q == XW'(FB_WIDTH - 1));
  assign last_y = (y_q == YW'(FB_HEIGHT - 1));

  // A frame-start pulse wins over a pixel offered in the same cycle.
  // The pack_cnt/pend_valid term only matters if a word could complete
  // while the previous one is still waiting for the port.
  assign rdy    = (state_q == S_ACTIVE) && !(pack_cnt_q == 4'hF && pend_valid_q)
                  && !pix_frame_start;
  assign accept = pix_valid && rdy;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pack_cnt_d   = pack_cnt_q;
    shift_d      = shift_q;
    waddr_d      = waddr_q;
    pend_valid_d = 1'b0;             // a pending word always drains in one cycle
    pend_last_d  = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    // An aborting frame-start suppresses the done pulse of the old frame.
    done_d       = pend_valid_q && pend_last_q && !pix_frame_start;

    case (state_q)
      S_IDLE:   ;
      S_ACTIVE: if (accept && last_x && last_y) state_d = S_FLUSH;
      S_FLUSH:  if (pend_valid_q && pend_last_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (pix_frame_start) begin
      // Restart: the partial word is dropped, an already pending word is
      // still written because pend_* is left untouched this cycle.
      state_d    = S_ACTIVE;
      x_d        = '0;
      y_d        = '0;
      pack_cnt_d = '0;
      shift_d    = '0;
      waddr_d    = '0;
    end else if (accept) begin
      shift_d    = {shift_q[29:0], pix_data};  // first pixel ends up in [31:30]
      pack_cnt_d = pack_cnt_q + 4'd1;
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (pack_cnt_q == 4'hF) begin
        pend_valid_d = 1'b1;
        pend_data_d  = {shift_q[29:0], pix_data};
        pend_addr_d  = waddr_q;
        pend_last_d  = last_x && last_y;
        waddr_d      = waddr_q + 11'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pack_cnt_q   <= '0;
      shift_q      <= '0;
      waddr_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pack_cnt_q   <= pack_cnt_d;
      shift_q      <= shift_d;
      waddr_q      <= waddr_d;
      pend_valid_q <= pend_valid_d;
      pend_last_q  <= pend_last_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      done_q       <= done_d;
    end
  end

  // Port A mux: pending pixel word first, otherwise the host passes through.
  // Host address bit 11 selects a region outside VRAM, so writes there are
  // not forwarded. All strobes are forced low while RESET is held.
  always_comb begin
    if (pend_valid_q) begin
      vram_addr    = pend_addr_q;
      vram_data    = pend_data_q;
      vram_byteena = 4'hF;
      vram_wren    = !RESET;
      vram_rden    = 1'b0;
    end else begin
      vram_addr    = AVL_ADDR[10:0];
      vram_data    = AVL_WRITEDATA;
      vram_byteena = AVL_BYTE_EN;
      vram_wren    = AVL_WRITE && AVL_CS && !AVL_ADDR[11] && !RESET;
      vram_rden    = AVL_READ && AVL_CS && !RESET;
    end
  end

  assign AVL_WAITREQUEST = pend_valid_q && AVL_CS && (AVL_READ || AVL_WRITE) && !RESET;
  assign pix_ready       = rdy && !RESET;
  assign frame_done      = done_q && !RESET;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: reset outputs, single-word packing,
// host collision, address bit 11, host read, abort, full frame with host
// traffic every cycle, and reset discarding a pending word.
module tb_fb_write_scheduler;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        pix_frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_data = 2'b00;
  logic        pix_ready, frame_done;
  logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [11:0] AVL_ADDR = 12'h0;
  logic [31:0] AVL_WRITEDATA = 32'h0;
  logic        AVL_WAITREQUEST;
  logic [10:0] vram_addr;
  logic [31:0] vram_data;
  logic [3:0]  vram_byteena;
  logic        vram_wren, vram_rden;

  fb_write_scheduler dut (
    .CLK(CLK), .RESET(RESET), .pix_frame_start(pix_frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .frame_done(frame_done), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_byteena(vram_byteena),
    .vram_wren(vram_wren), .vram_rden(vram_rden)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [10:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  wr_t wq[$];            // pixel-side VRAM writes (host filler writes filtered)
  int  cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int  stall_cnt = 0, stall_leak = 0;
  int  checks = 0, failures = 0;

  // Host filler traffic uses 0x7FF/DEADBEEF so it can be told apart.
  always @(negedge CLK) begin
    if (!RESET) begin
      cyc <= cyc + 1;
      if (vram_wren && !(vram_addr == 11'h7FF && vram_data == 32'hDEADBEEF)) begin
        wq.push_back('{vram_addr, vram_data, vram_byteena});
        last_wr_cyc <= cyc;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (AVL_WAITREQUEST) begin
        stall_cnt <= stall_cnt + 1;
        if (vram_wren && vram_addr == 11'h7FF && vram_data == 32'hDEADBEEF)
          stall_leak <= stall_leak + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Offer one pixel for one cycle; returns pix_ready seen mid-cycle.
  task automatic pix(input logic [1:0] d, output bit rdy);
    pix_valid = 1'b1;
    pix_data  = d;
    @(negedge CLK);
    rdy = pix_ready;
    step();
  endtask

  task automatic host(input logic cs, input logic rd, input logic wr,
                      input logic [11:0] a, input logic [31:0] d);
    AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = a;
    AVL_WRITEDATA = d; AVL_BYTE_EN = 4'hF;
  endtask

  task automatic start_frame();
    pix_valid = 1'b0;
    pix_frame_start = 1'b1;
    step();
    pix_frame_start = 1'b0;
  endtask

  initial begin
    bit r;
    int bad, n0, s0, d0, err;
    logic [1:0] wv;

    // ---- reset: strobes low even with host read/write presented
    host(1, 1, 1, 12'h005, 32'h1234_5678);
    pix_valid = 1'b1;
    step(); step();
    @(negedge CLK);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wren", vram_wren, 0);
    chk("rst_rden", vram_rden, 0);
    chk("rst_waitreq", AVL_WAITREQUEST, 0);
    chk("rst_frame_done", frame_done, 0);
    step();
    RESET = 1'b0;
    host(0, 0, 0, 12'h0, 32'h0);

    // ---- idle ignores pixels
    @(negedge CLK);
    chk("idle_pix_ready", pix_ready, 0);
    step();
    pix_valid = 1'b0;
    chk("idle_no_write", wq.size(), 0);

    // ---- single word: 0,1,2,3 x4 -> 0x1B1B1B1B at addr 0
    start_frame();
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      pix(2'(k % 4), r);
      if (!r) bad++;
    end
    pix_valid = 1'b0;
    chk("w0_ready", bad, 0);
    @(negedge CLK);
    chk("w0_wren", vram_wren, 1);
    chk("w0_addr", vram_addr, 0);
    chk("w0_data", vram_data, 32'h1B1B1B1B);
    chk("w0_be", vram_byteena, 4'hF);
    step();
    @(negedge CLK);
    chk("w0_wren_clear", vram_wren, 0);
    step();

    // ---- host collision on word 1 (pixels 3,2,1,0 -> 0xE4E4E4E4)
    for (int k = 0; k < 16; k++) pix(2'(3 - k % 4), r);
    pix_valid = 1'b0;
    host(1, 0, 1, 12'h005, 32'hCAFE0005);
    @(negedge CLK);
    chk("col_waitreq", AVL_WAITREQUEST, 1);
    chk("col_pix_addr", vram_addr, 1);
    chk("col_pix_data", vram_data, 32'hE4E4E4E4);
    step();
    @(negedge CLK);
    chk("col_waitreq_end", AVL_WAITREQUEST, 0);
    chk("col_host_wren", vram_wren, 1);
    chk("col_host_addr", vram_addr, 11'h005);
    chk("col_host_data", vram_data, 32'hCAFE0005);
    step();

    // ---- host address bit 11 and host read
    host(1, 0, 1, 12'h805, 32'h0BAD0805);
    @(negedge CLK);
    chk("a11_wren", vram_wren, 0);
    chk("a11_waitreq", AVL_WAITREQUEST, 0);
    step();
    host(1, 1, 0, 12'h123, 32'h0);
    @(negedge CLK);
    chk("rd_rden", vram_rden, 1);
    chk("rd_addr", vram_addr, 11'h123);
    step();
    host(0, 0, 0, 12'h0, 32'h0);

    // ---- abort after 170 pixels; start pulse wins over an offered pixel
    start_frame();
    n0 = wq.size();
    d0 = done_cnt;
    for (int k = 0; k < 170; k++) pix(2'b11, r);
    pix_valid = 1'b1;
    pix_data  = 2'b10;
    pix_frame_start = 1'b1;
    @(negedge CLK);
    chk("abort_ready_low", pix_ready, 0);
    step();
    pix_frame_start = 1'b0;
    for (int k = 0; k < 16; k++) pix(2'b01, r);
    pix_valid = 1'b0;
    step(); step();
    chk("abort_nwr", wq.size() - n0, 11);
    chk("abort_w0_addr", wq[n0].a, 0);
    chk("abort_w0_data", wq[n0].d, 32'hFFFFFFFF);
    chk("abort_w9_addr", wq[n0 + 9].a, 9);
    chk("abort_new_addr", wq[n0 + 10].a, 0);
    chk("abort_new_data", wq[n0 + 10].d, 32'h55555555);
    chk("abort_no_done", done_cnt - d0, 0);

    // ---- full frame with host writes every cycle
    start_frame();
    step();   // let the monitor catch up before snapshotting
    n0 = wq.size();
    s0 = stall_cnt;
    d0 = done_cnt;
    host(1, 0, 1, 12'h7FF, 32'hDEADBEEF);
    start_frame();
    bad = 0;
    for (int i = 0; i < 23040; i++) begin
      wv = 2'((i >> 4) % 4);
      pix(wv, r);
      if (!r) bad++;
    end
    pix_valid = 1'b0;
    step(); step(); step();
    host(0, 0, 0, 12'h0, 32'h0);
    step();
    chk("ff_ready_always", bad, 0);
    chk("ff_nwr", wq.size() - n0, 1440);
    err = 0;
    for (int j = 0; j < 1440 && n0 + j < wq.size(); j++) begin
      wv = 2'(j % 4);
      if (wq[n0 + j].a != 11'(j) || wq[n0 + j].d != {16{wv}}) err++;
    end
    chk("ff_addr_data_order", err, 0);
    chk("ff_stalls", stall_cnt - s0, 1440);
    chk("ff_stall_leak", stall_leak, 0);
    chk("ff_done_cnt", done_cnt - d0, 1);
    chk("ff_done_timing", done_cyc - last_wr_cyc, 1);
    pix_valid = 1'b1;
    @(negedge CLK);
    chk("ff_idle_after", pix_ready, 0);
    step();
    pix_valid = 1'b0;

    // ---- reset during the pending cycle discards the word
    start_frame();
    for (int k = 0; k < 16; k++) pix(2'b10, r);
    pix_valid = 1'b0;
    n0 = wq.size();
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_pend_wren", vram_wren, 0);
    step();
    RESET = 1'b0;
    step(); step();
    chk("rst_pend_never_written", wq.size() - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160: pixels per line; a multiple of 16.
REQ-002 SHALL have parameter FB_HEIGHT, default 144: lines per frame.
REQ-003 SHALL have port CLK, in, 1: the single clock for all logic.
REQ-004 SHALL have port RESET, in, 1: synchronous, active-high reset.
REQ-005 SHALL have port pix_frame_start, in, 1: single-cycle pulse that starts a new frame.
REQ-006 SHALL have port pix_valid, in, 1: a pixel is offered.
REQ-007 SHALL have port pix_data, in, 2: pixel shade, 00 white to 11 black.
REQ-008 SHALL have port pix_ready, out, 1: the block accepts the pixel this cycle.
REQ-009 SHALL have port frame_done, out, 1: single-cycle pulse when the last frame word is written to VRAM.
REQ-010 SHALL have host ports AVL_READ, AVL_WRITE, AVL_CS (in, 1), AVL_BYTE_EN (in, 4), AVL_ADDR (in, 12) and AVL_WRITEDATA (in, 32): the Avalon-MM host request.
REQ-011 SHALL have port AVL_WAITREQUEST, out, 1: the host request is stalled this cycle.
REQ-012 SHALL have VRAM port A outputs vram_addr (out, 11), vram_data (out, 32), vram_byteena (out, 4), vram_wren (out, 1) and vram_rden (out, 1).

Function
REQ-013 SHALL implement states IDLE, ACTIVE and FLUSH.
- IDLE to ACTIVE on pix_frame_start.
- ACTIVE to FLUSH when the final pixel (x=FB_WIDTH-1, y=FB_HEIGHT-1) is accepted.
- FLUSH to IDLE when the final word is written.
REQ-014 SHALL hold pix_ready=0 in IDLE and FLUSH.
REQ-015 SHALL, in ACTIVE, drive pix_ready = NOT(pack_cnt==15 AND pend_valid).
REQ-016 SHALL accept a pixel on any cycle with pix_valid AND pix_ready.
REQ-017 SHALL pack accepted pixels MSB-first into a 32-bit shift word: pixel k of a word occupies bits [31-2k:30-2k].
REQ-018 SHALL use a 4-bit pack_cnt that wraps from 15 to 0.
REQ-019 SHALL, when the 16th pixel of a word is accepted, move the completed word into the pending register.
- pend_valid=1 on the next cycle.
- pend_addr = current word address.
REQ-020 SHALL keep a word address counter: 0 at frame start, +1 per completed word, range 0..(FB_WIDTH/16*FB_HEIGHT-1), i.e. 0..1439 by default, equal to y*10 + (x>>4).
REQ-021 SHALL give the pending word absolute priority on VRAM port A.
- Whenever pend_valid=1: vram_wren=1, vram_addr=pend_addr, vram_data=pend word, vram_byteena=4'hF, vram_rden=0.
- pend_valid clears on the following cycle.
REQ-022 SHALL, when pend_valid=0, pass the host through combinationally.
- vram_addr = AVL_ADDR[10:0], vram_data = AVL_WRITEDATA, vram_byteena = AVL_BYTE_EN.
- vram_wren = AVL_WRITE AND AVL_CS AND NOT AVL_ADDR[11].
- vram_rden = AVL_READ AND AVL_CS.
REQ-023 SHALL drive AVL_WAITREQUEST = pend_valid AND AVL_CS AND (AVL_READ OR AVL_WRITE).
- A stalled host request SHALL NOT reach VRAM.
- A host stall SHALL last at most 1 cycle per 16 accepted pixels.
REQ-024 SHALL write a pixel to VRAM 1 cycle after the cycle that accepts the 16th pixel of its word.
REQ-025 SHALL pulse frame_done for 1 cycle, in the cycle after the final word's vram_wren.
REQ-026 SHALL handle pix_frame_start in ACTIVE or FLUSH as follows.
- Clear x, y, pack_cnt and the word address; discard the partial shift word.
- Still write an already-pending word.
- Enter ACTIVE.
- Do not pulse frame_done for the aborted frame.
REQ-027 SHALL, when pix_frame_start coincides with pixel acceptance, let the pulse win: that pixel is dropped and pix_ready=0 that cycle.
REQ-028 SHALL ignore pix_valid in IDLE; it has no side effects.

Reset
REQ-029 SHALL, on RESET=1 at a CLK edge, enter IDLE and clear all counters, the shift word and pend_valid.
REQ-030 SHALL, during reset, drive pix_ready=0, frame_done=0, vram_wren=0, vram_rden=0 and AVL_WAITREQUEST=0.
REQ-031 SHALL discard a pending word when reset is asserted mid-frame; it is never written.

Verification
REQ-032 SHALL verify single word: frame start, then pixels 0,1,2,3 repeated to 16 pixels -> one write to addr 0, data 0x1B1B1B1B, byteena F, 1 cycle after the 16th accept.
REQ-033 SHALL verify full frame: 23040 back-to-back pixels -> 1440 writes, addresses 0..1439 in order, exactly one frame_done pulse after the write to 1439, then state IDLE.
REQ-034 SHALL verify host collision: host write to 0x005 issued in the pend_valid cycle -> AVL_WAITREQUEST=1 for 1 cycle, the pixel word is written first, then the host word at 0x005.
REQ-035 SHALL verify host address bit 11: host write with AVL_ADDR=0x805 -> vram_wren=0 and AVL_WAITREQUEST=0.
REQ-036 SHALL verify abort: pix_frame_start after 170 pixels -> word 0 written, the 10 partial pixels lost, the next write lands at addr 0, no frame_done.
REQ-037 SHALL verify backpressure: host writes issued every cycle during pixel streaming -> pix_ready stays 1 and only the pend cycles stall the host.
